fifo_rd_stream: RTL and testbench

Read-side drain stage that sits directly downstream of the synchronous FIFO. It pops words from the FIFO's `rd_en`/`data_out` port, which has one-cycle read latency. It presents them on a valid/ready stream through a 3-entry output buffer, so a stalled consumer never loses in-flight words. It also supplies a flush mode that empties the FIFO and discards the words, and an optional underflow check.

---
 rtl/fifo_rd_stream.sv | 119 +++++++++++
 tb/tb_fifo_rd_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain stage with 3-entry stream buffer and flush mode
// Optional underflow check enabled by defining FIFO_RD_STREAM_UFLOW_CHK_EN.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  flush_done,
  output logic                  rd_err
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [1:0]            occ;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] mem [0:2];
  logic                  capture;
  logic                  pop;
  logic                  uflow_drop;
  logic                  flush_enter;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read issue looks only at registered state and FIFO flags, never at m_ready.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        fifo_rd_en = en & ~fifo_empty & (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        fifo_rd_en = ~fifo_empty;
        if (fifo_empty && !inflight) begin
          state_nxt  = RUN;
          flush_done = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!rst_n) begin
      fifo_rd_en = 1'b0;
      flush_done = 1'b0;
    end
  end

  assign flush_enter = (state == RUN) & flush;
  assign capture     = inflight & ~uflow_drop & (state == RUN);
  assign m_valid     = (occ != 2'd0);
  assign m_data      = mem[rd_ptr];
  assign pop         = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      occ      <= 2'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      // Flush entry wins over any capture or pop landing on the same edge.
      if (flush_enter) begin
        occ    <= 2'd0;
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
      end else begin
        if (capture) begin
          mem[wr_ptr] <= fifo_data_out;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({capture, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

`ifdef FIFO_RD_STREAM_UFLOW_CHK_EN
  logic rd_err_q;

  assign uflow_drop = inflight & fifo_underflow;

  always_ff @(posedge clk) begin
    if (!rst_n) rd_err_q <= 1'b0;
    else if (uflow_drop) rd_err_q <= 1'b1;
  end

  assign rd_err = rd_err_q;
`else
  logic uflow_unused;

  assign uflow_unused = fifo_underflow;
  assign uflow_drop   = 1'b0;
  assign rd_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with a queue-based FIFO model
module tb_fifo_rd_stream;
  localparam int W = 16;
`ifdef FIFO_RD_STREAM_UFLOW_CHK_EN
  localparam bit UF = 1'b1;
`else
  localparam bit UF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_underflow = 1'b0;
  logic         fifo_rd_en;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         flush_done;
  logic         rd_err;

  fifo_rd_stream #(.FIFO_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .flush_done(flush_done), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           deliv_cyc[$];
  int           n_checks = 0, n_fail = 0;
  int           rd_count = 0, deliv = 0, drops = 0, disc = 0, fd_count = 0;
  int           cyc = 0, rd_cyc_first = -1;
  bit           flushing = 0, uflow_arm = 0, rd_q = 0, hold_prev = 0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int lim, input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO model: data and underflow appear the cycle after a read request.
  initial forever begin
    tick();
    fifo_underflow = 1'b0;
    if (rd_q) begin
      check("rd_while_empty", fifo_q.size() == 0, 0);
      if (fifo_q.size() != 0) fifo_data_out = fifo_q.pop_front();
      if (uflow_arm) begin
        fifo_underflow = 1'b1;
        uflow_arm = 0;
        if (UF) begin
          drops++;
          for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i] == fifo_data_out) begin
              exp_q.delete(i);
              break;
            end
        end
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor: scoreboard pops on each handshake, plus hold and occupancy invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en) begin
        rd_count++;
        if (flushing) disc++;
        if (rd_cyc_first < 0) rd_cyc_first = cyc;
      end
      rd_q = fifo_rd_en;
      if (flush_done) begin
        fd_count++;
        flushing = 0;
      end
      if (hold_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        deliv++;
        deliv_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 1);
        else check("m_data", m_data, exp_q.pop_front());
      end
      hold_prev = m_valid && !m_ready && !flush;
      prev_data = m_data;
      check("outstanding_le_3", (rd_count - deliv - drops - disc) <= 3, 1);
    end else begin
      rd_q = 0;
      hold_prev = 0;
    end
  end

  initial begin
    int base, dbase, fbase, k;
    // Reset with a non-empty FIFO
    push_word(16'h1234);
    en = 1;
    m_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_rd_err", rd_err, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    check("rd_en_after_reset", fifo_rd_en, 1);
    wait_drain(20, "drain_reset");

    // Streaming latency and throughput
    tick();
    rd_cyc_first = -1;
    deliv_cyc.delete();
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    wait_drain(40, "drain_stream");
    check("stream_count", deliv_cyc.size(), 8);
    if (deliv_cyc.size() == 8) begin
      check("stream_latency", deliv_cyc[0] - rd_cyc_first, 2);
      check("stream_back_to_back", deliv_cyc[7] - deliv_cyc[0], 7);
    end

    // Backpressure
    m_ready = 0;
    base = rd_count;
    dbase = deliv;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    repeat (10) tick();
    check("bp_reads", rd_count - base, 3);
    @(negedge clk);
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, 16'h0001);
    tick();
    m_ready = 1;
    wait_drain(40, "drain_bp");
    check("bp_delivered", deliv - dbase, 8);

    // Alternating ready with random data
    for (int i = 0; i < 12; i++) push_word(W'($urandom));
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      m_ready = ~m_ready;
      k++;
    end
    check("drain_alt", exp_q.size(), 0);
    m_ready = 1;

    // Flush with two buffered words and three left in the FIFO
    tick();
    m_ready = 0;
    en = 0;
    for (int i = 0; i < 5; i++) push_word(W'($urandom));
    tick();
    base = rd_count;
    en = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rd_count - base < 2 && k < 10);
    check("flush_prefill_reads", rd_count - base, 2);
    tick();
    en = 0;
    repeat (2) tick();
    @(negedge clk);
    check("flush_pre_valid", m_valid, 1);
    tick();
    flush = 1;
    flushing = 1;
    disc += rd_count - deliv - drops - disc;
    exp_q.delete();
    fbase = fd_count;
    tick();
    flush = 0;
    @(negedge clk);
    check("flush_valid_low", m_valid, 0);
    k = 0;
    while (fd_count == fbase && k < 30) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check("flush_done_pulses", fd_count - fbase, 1);
    check("flush_fifo_empty", fifo_q.size(), 0);
    dbase = deliv;
    en = 1;
    m_ready = 1;
    push_word(16'hAAAA);
    push_word(16'hBBBB);
    wait_drain(20, "drain_post_flush");
    check("post_flush_delivered", deliv - dbase, 2);

    // Underflow on the first beat of a burst
    tick();
    uflow_arm = 1;
    for (int i = 0; i < 6; i++) push_word(W'(16'h5000 + i));
    wait_drain(40, "drain_uflow");
    check("rd_err_set", rd_err, UF);
    repeat (5) tick();
    check("rd_err_sticky", rd_err, UF);
    push_word(16'h6001);
    push_word(16'h6002);
    wait_drain(20, "drain_after_uflow");
    check("rd_err_sticky2", rd_err, UF);
    rst_n = 0;
    repeat (2) tick();
    @(negedge clk);
    check("rd_err_cleared", rd_err, 0);
    tick();
    rst_n = 1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
